// File: rtl/enc_16x4_seq.sv
// enc_16x4_seq -- sequential 16-to-4 encoder (inverse of a 4x16 decoder).
//
// A 16-bit line word D is captured through a valid/ready handshake. Each set
// bit is then emitted as its 4-bit index {X,Y,Z,W}, one index per output
// handshake. The scan order is lowest-first (LSB_FIRST=1) or highest-first.
// Words that are not one-hot are flagged so faulty decoder outputs can be
// encoded back and checked by a scoreboard.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   D is valid this cycle
//   in_ready   block can accept a word (IDLE and not in reset)
//   D[15:0]    line word, D[i] means index i
//   out_valid  {X,Y,Z,W} holds a valid code
//   out_ready  consumer accepts the current code
//   X,Y,Z,W    code bits 3..0
//   out_last   current code is the final one for the captured word
//   err_zero   one-cycle pulse after an all-zero word is accepted
//   err_multi  captured word has more than one bit set (held while emitting)
//   count[4:0] number of set bits in the captured word
module enc_16x4_seq #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] D,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        X,
  output logic        Y,
  output logic        Z,
  output logic        W,
  output logic        out_last,
  output logic        err_zero,
  output logic        err_multi,
  output logic [4:0]  count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  logic [15:0] pending;
  logic [3:0]  code;

  logic [4:0]  d_pop;
  logic [15:0] pend_next;
  logic [4:0]  next_pop;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  // Index of the set bit to emit next. The loop direction is chosen so the
  // last match wins: scanning downward leaves the lowest set bit, scanning
  // upward leaves the highest.
  function automatic logic [3:0] pick_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = 15; i >= 0; i--) begin
        if (v[i]) idx = 4'(i);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) idx = 4'(i);
      end
    end
    return idx;
  endfunction

  assign d_pop     = popcount16(D);
  // The code register always names a set bit of pending while emitting, so
  // clearing that one bit retires exactly the code just handed off.
  assign pend_next = pending & ~(16'd1 << code);
  assign next_pop  = popcount16(pend_next);

  // in_ready is forced low while rst is held, independent of the state.
  assign in_ready = (state == IDLE) && !rst;

  assign {X, Y, Z, W} = code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      code      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_zero  <= 1'b0;
      err_multi <= 1'b0;
      count     <= '0;
    end else begin
      err_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            pending <= D;
            count   <= d_pop;
            if (D == '0) begin
              err_zero <= 1'b1;
            end else begin
              state     <= EMIT;
              out_valid <= 1'b1;
              code      <= pick_index(D);
              out_last  <= (d_pop == 5'd1);
              err_multi <= (d_pop > 5'd1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending <= pend_next;
            if (pend_next == '0) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              err_multi <= 1'b0;
              code      <= '0;
            end else begin
              code     <= pick_index(pend_next);
              out_last <= (next_pop == 5'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
